// File: rtl/pipe_ctrl.sv
// Pipeline sequencing unit: per-stage valid/PC tracking, stall-to-hold expansion,
// wrong-path kill on a resolved jump, and retire/stall/flush trace counters.
module pipe_ctrl #(
  parameter int                STAGES   = 5,
  parameter int                PC_W     = 32,
  parameter int                CNT_W    = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       f_valid,
  input  logic [PC_W-1:0]            f_pc,
  input  logic [STAGES-1:0]          stall_req,
  input  logic                       flush_req,
  input  logic [$clog2(STAGES)-1:0]  flush_stage,
  output logic [STAGES-1:0]          hold,
  output logic [STAGES-1:0]          nop,
  output logic [STAGES*PC_W-1:0]     stage_pc,
  output logic                       retire,
  output logic [PC_W-1:0]            retire_pc,
  output logic [CNT_W-1:0]           retired_cnt,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int              FS_W   = $clog2(STAGES);
  localparam logic [FS_W-1:0] FS_MAX = FS_W'(STAGES - 2);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [PC_W-1:0]   pc_q [STAGES];
  logic [PC_W-1:0]   pc_d [STAGES];
  logic [STAGES-1:0] hold_w;
  logic [STAGES-1:0] kill_w;
  logic [FS_W-1:0]   fs_w;
  logic              flush_ok_w;
  logic              retire_w;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  // A stall in stage i must also freeze every younger (lower-index) stage.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    hold_w = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc       = acc | stall_req[i];
      hold_w[i] = acc;
    end
  end

  // The last stage has nowhere to send a jump, so the resolver index is clamped.
  always_comb begin
    fs_w       = (flush_stage > FS_MAX) ? FS_MAX : flush_stage;
    flush_ok_w = flush_req & ~hold_w[fs_w];
    kill_w     = '0;
    for (int i = 0; i < STAGES; i++) begin
      kill_w[i] = flush_ok_w && (i <= int'(fs_w));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pc_d[gi]    = hold_w[gi] ? pc_q[gi] : f_pc;
        assign valid_d[gi] = kill_w[gi] ? 1'b0 :
                             hold_w[gi] ? valid_q[gi] : f_valid;
      end else begin : g_body
        assign pc_d[gi]    = hold_w[gi] ? pc_q[gi] : pc_q[gi-1];
        // A held neighbour below leaves a bubble behind in this stage.
        assign valid_d[gi] = kill_w[gi] ? 1'b0 :
                             hold_w[gi] ? valid_q[gi] :
                             (hold_w[gi-1] ? 1'b0 : valid_q[gi-1]);
      end
      assign stage_pc[gi*PC_W +: PC_W] = pc_q[gi];
    end
  endgenerate

  assign retire_w      = valid_q[STAGES-1] & ~hold_w[STAGES-1];
  assign retired_cnt_d = retired_cnt_q + CNT_W'(retire_w);
  assign stall_cnt_d   = stall_cnt_q + CNT_W'(|stall_req);
  assign flush_cnt_d   = flush_cnt_q + CNT_W'(flush_ok_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i] <= RESET_PC;
      end
    end else begin
      valid_q       <= valid_d;
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign hold        = hold_w;
  assign nop         = ~valid_q;
  assign retire      = retire_w;
  assign retire_pc   = pc_q[STAGES-1];
  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run,
// compared against a stage-occupancy reference model.
module tb_pipe_ctrl;

  localparam int          S   = 5;
  localparam int          PW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0F00;

  logic            clk = 1'b0;
  logic            reset;
  logic            f_valid;
  logic [PW-1:0]   f_pc;
  logic [S-1:0]    stall_req;
  logic            flush_req;
  logic [2:0]      flush_stage;

  logic [S-1:0]    hold, nop, hold2, nop2;
  logic [S*PW-1:0] stage_pc, stage_pc2;
  logic            retire, retire2;
  logic [PW-1:0]   retire_pc, retire_pc2;
  logic [31:0]     retired_cnt, stall_cnt, flush_cnt;
  logic [3:0]      retired_cnt2, stall_cnt2, flush_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each stage holds, and the trace counters.
  bit          mv [S];
  logic [31:0] mp [S];
  logic [31:0] mret, mstall, mflush;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(S), .PC_W(PW), .CNT_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
    .hold(hold), .nop(nop), .stage_pc(stage_pc), .retire(retire),
    .retire_pc(retire_pc), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.STAGES(S), .PC_W(PW), .CNT_W(4), .RESET_PC(RPC)) dut_w4 (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_pc(f_pc),
    .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
    .hold(hold2), .nop(nop2), .stage_pc(stage_pc2), .retire(retire2),
    .retire_pc(retire_pc2), .retired_cnt(retired_cnt2), .stall_cnt(stall_cnt2),
    .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Highest stage index with a stall request, -1 when none.
  function automatic int top_stall();
    int t = -1;
    for (int i = 0; i < S; i++) if (stall_req[i]) t = i;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      mp[i] = RPC;
    end
    mret = 0; mstall = 0; mflush = 0;
  endtask

  task automatic check_all();
    int top = top_stall();
    logic [S-1:0] eh, en;
    for (int i = 0; i < S; i++) begin
      eh[i] = (i <= top);
      en[i] = !mv[i];
    end
    chk("hold", hold, eh);
    chk("nop", nop, en);
    chk("retire", retire, mv[S-1] && (top < S - 1));
    chk("retire_pc", retire_pc, mp[S-1]);
    for (int i = 0; i < S; i++) chk("stage_pc", stage_pc[i*PW +: PW], mp[i]);
    chk("retired_cnt", retired_cnt, mret);
    chk("stall_cnt", stall_cnt, mstall);
    chk("flush_cnt", flush_cnt, mflush);
    chk("retired_cnt_w4", retired_cnt2, mret[3:0]);
  endtask

  // Check outputs against the model, then advance both across one rising edge.
  task automatic step();
    int top, fs;
    bit fok;
    bit nv [S];
    logic [31:0] np [S];
    #1;
    check_all();
    top = top_stall();
    fs  = (int'(flush_stage) > S - 2) ? S - 2 : int'(flush_stage);
    fok = flush_req && !(fs <= top);
    for (int i = 0; i < S; i++) begin
      if (i <= top) begin
        nv[i] = mv[i];
        np[i] = mp[i];
      end else if (i == 0) begin
        nv[i] = f_valid;
        np[i] = f_pc;
      end else begin
        nv[i] = (i - 1 <= top) ? 1'b0 : mv[i-1];
        np[i] = mp[i-1];
      end
      if (fok && i <= fs) nv[i] = 1'b0;
    end
    if (mv[S-1] && top < S - 1) mret = mret + 1;
    if (stall_req != '0) mstall = mstall + 1;
    if (fok) mflush = mflush + 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      mv[i] = nv[i];
      mp[i] = np[i];
    end
  endtask

  task automatic idle_inputs();
    f_valid = 1'b0; f_pc = '0; stall_req = '0; flush_req = 1'b0; flush_stage = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; its effect must show with no clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_nop", nop, {S{1'b1}});
    chk("rst_retire", retire, 1'b0);
    chk("rst_retired_cnt", retired_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    for (int i = 0; i < S; i++) chk("rst_stage_pc", stage_pc[i*PW +: PW], RPC);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int c = 0; c < S; c++) begin
      f_valid = 1'b1; f_pc = base + 32'(4 * c);
      step();
    end
  endtask

  initial begin
    int k;
    bit held0;
    logic [31:0] pc_ctr;
    reset = 1'b1;
    idle_inputs();
    #2;
    async_reset();

    // Plain stream of 8 instructions.
    for (int c = 0; c < 13; c++) begin
      f_valid = (c < 8); f_pc = (c < 8) ? 32'(4 * c) : 32'd0;
      step();
      if (c == 4) begin
        chk("t1_first_retire", retire, 1'b1);
        chk("t1_first_retire_pc", retire_pc, 32'd0);
      end
    end
    chk("t1_retired_8", retired_cnt, 32'd8);

    // One-cycle stall in stage 2 mid-stream; fetch re-presents while held.
    async_reset();
    k = 0;
    for (int c = 0; c < 14; c++) begin
      stall_req = (c == 4) ? 5'b00100 : 5'b00000;
      f_valid = (k < 8); f_pc = 32'(4 * k);
      if (c == 4) begin
        #1;
        chk("t2_hold", hold, 5'b00111);
      end
      step();
      if (c == 4) begin
        chk("t2_bubble_nop3", nop[3], 1'b1);
        chk("t2_stall_cnt", stall_cnt, 32'd1);
      end
      if (stall_req == '0 && f_valid) k++;
    end
    chk("t2_retired_8", retired_cnt, 32'd8);

    // Honoured flush from stage 2 with every stage full.
    async_reset();
    fill(32'h40);
    flush_req = 1'b1; flush_stage = 3'd2; f_valid = 1'b1; f_pc = 32'h54;
    step();
    chk("t3_nop_killed", nop[2:0], 3'b111);
    chk("t3_jump_pc_s3", stage_pc[3*PW +: PW], 32'h48);
    chk("t3_flush_cnt", flush_cnt, 32'd1);
    idle_inputs();

    // Flush blocked by a stall on the resolving stage, honoured once released.
    async_reset();
    fill(32'h80);
    stall_req = 5'b01000; flush_req = 1'b1; flush_stage = 3'd2;
    f_valid = 1'b1; f_pc = 32'h94;
    step();
    chk("t4_blocked_flush_cnt", flush_cnt, 32'd0);
    chk("t4_blocked_nop", nop[3:0], 4'b0000);
    stall_req = '0;
    step();
    chk("t4_late_flush_cnt", flush_cnt, 32'd1);
    chk("t4_late_nop", nop[2:0], 3'b111);
    flush_req = 1'b0;

    // Keep streaming, then reset with instructions in flight.
    for (int c = 0; c < 3; c++) begin
      f_valid = 1'b1; f_pc = 32'hA0 + 32'(4 * c);
      step();
    end
    async_reset();

    // 17 retirements wrap a 4-bit counter to 1.
    for (int c = 0; c < 22; c++) begin
      f_valid = (c < 17); f_pc = 32'h200 + 32'(4 * c);
      step();
    end
    chk("t6_wrap_w4", retired_cnt2, 4'd1);
    chk("t6_count_w32", retired_cnt, 32'd17);

    // Randomized traffic with a reset partway through.
    async_reset();
    held0 = 1'b0;
    pc_ctr = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        async_reset();
        held0 = 1'b0;
      end
      if (!held0) begin
        f_valid = ($urandom_range(0, 3) != 0);
        f_pc = pc_ctr;
        if (f_valid) pc_ctr = pc_ctr + 4;
      end
      for (int i = 0; i < S; i++) stall_req[i] = ($urandom_range(0, 7) == 0);
      flush_req = ($urandom_range(0, 5) == 0);
      flush_stage = 3'($urandom_range(0, 7));
      held0 = (stall_req != '0);
      step();
    end
    #1;
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
